// File: rtl/spi_regfile_peripheral.sv
// -----------------------------------------------------------------------------
// spi_regfile_peripheral
//   SPI-slave register file. Frames are MSB first: R/W bit (1 = write), ADDR_W
//   address bits, then DATA_W data bits. Writes commit on chip-select release,
//   and only when the frame length is exactly right. Reads return the addressed
//   register on MISO during the data phase. The SPI mode (CPOL/CPHA) is set by
//   parameters. All SPI pins are asynchronous to clk and are oversampled.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sclk_raw   SPI clock (asynchronous)
//   mosi_raw   SPI data in (asynchronous)
//   cs_n_raw   SPI chip select, active low (asynchronous)
//   miso       SPI data out (held 0 when not driving)
//   miso_oe    MISO pad output enable: high only in the data phase of a read
//   regs_flat  register contents; reg i is at [i*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse when a write is committed
//   wr_addr    address of the last committed write
//   frame_err  one-cycle pulse when a frame of the wrong length is rejected
// -----------------------------------------------------------------------------
module spi_regfile_peripheral #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk_raw,
  input  logic                       mosi_raw,
  input  logic                       cs_n_raw,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int   FRAME_W   = 1 + ADDR_W + DATA_W;
  localparam int   CNT_W     = $clog2(FRAME_W + 2);
  localparam logic SCLK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus one history flop each for sclk and cs_n
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_d, r_cs_d;

  // The flops reset to the idle bus state. A cs_n_raw that is already low when
  // reset is released is therefore seen as a fresh frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= SCLK_IDLE;
      r_cs_d      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage take the previous
      // stage's old value; blocking assignments would collapse the chain.
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_raw};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_raw};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_raw};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk, w_mosi, w_cs_n;
  logic w_sclk_rise, w_sclk_fall, w_lead_edge, w_trail_edge;
  logic w_sample_edge, w_shift_edge, w_cs_fall, w_cs_rise;

  assign w_sclk        = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise   = w_sclk & ~r_sclk_d;
  assign w_sclk_fall   = ~w_sclk & r_sclk_d;
  assign w_lead_edge   = (CPOL == 0) ? w_sclk_rise : w_sclk_fall;
  assign w_trail_edge  = (CPOL == 0) ? w_sclk_fall : w_sclk_rise;
  assign w_sample_edge = (CPHA == 0) ? w_lead_edge : w_trail_edge;
  assign w_shift_edge  = (CPHA == 0) ? w_trail_edge : w_lead_edge;
  assign w_cs_fall     = r_cs_d & ~w_cs_n;
  assign w_cs_rise     = ~r_cs_d & w_cs_n;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [ADDR_W-1:0]   r_cmd;          // command bits gathered so far
  logic [DATA_W-1:0]   r_data;         // data bits gathered so far
  logic [CNT_W-1:0]    r_cnt;          // sample edges seen, saturates at FRAME_W+1
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_rd_buf;
  logic                r_rd_loaded;
  logic                r_miso, r_miso_oe;
  logic                r_commit_wr, r_commit_err;
  logic [ADDR_W-1:0]   r_commit_addr;
  logic [DATA_W-1:0]   r_commit_data;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [ADDR_W:0]     w_cmd_next;     // {rw, addr} once the last command bit is in
  logic [DATA_W-1:0]   w_data_next;
  logic [DATA_W-1:0]   w_rd_shifted;
  logic [DATA_W-1:0]   w_rd_val;
  logic                w_addr_ok;

  assign w_cmd_next   = {r_cmd, w_mosi};
  assign w_data_next  = DATA_W'({r_data, w_mosi});
  assign w_rd_shifted = r_rd_buf << 1;

  // Read mux and address range check. Out-of-range addresses read as zero.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_rd_val  = '0;
    w_addr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr == ADDR_W'(i)) begin
        w_rd_val  = r_regs[i];
        w_addr_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_data        <= '0;
      r_cnt         <= '0;
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_rd_buf      <= '0;
      r_rd_loaded   <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_commit_wr   <= 1'b0;
      r_commit_err  <= 1'b0;
      r_commit_addr <= '0;
      r_commit_data <= '0;
    end else if (w_cs_rise) begin
      // End of frame from any state. The decision is registered here and
      // applied to the register file on the following cycle.
      r_state       <= ST_IDLE;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_rd_loaded   <= 1'b0;
      r_commit_wr   <= (r_cnt == CNT_W'(FRAME_W)) && r_rw && w_addr_ok;
      r_commit_err  <= (r_cnt != '0) && (r_cnt != CNT_W'(FRAME_W));
      r_commit_addr <= r_addr;
      r_commit_data <= r_data;
    end else begin
      r_commit_wr  <= 1'b0;
      r_commit_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_cmd   <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_sample_edge) begin
            r_cmd <= w_cmd_next[ADDR_W-1:0];
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(ADDR_W)) begin
              r_rw      <= w_cmd_next[ADDR_W];
              r_addr    <= w_cmd_next[ADDR_W-1:0];
              r_miso_oe <= ~w_cmd_next[ADDR_W];
              r_state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_sample_edge) begin
            if (r_cnt < CNT_W'(FRAME_W)) begin
              r_data <= w_data_next;
              r_cnt  <= r_cnt + 1'b1;
            end else begin
              // Overrun: bits past the frame are dropped, count sticks one past.
              r_cnt <= CNT_W'(FRAME_W + 1);
            end
          end
          // Read data leaves on shift edges so it is stable for the master's
          // next sample edge. The first shift edge loads the buffer.
          if (w_shift_edge && !r_rw) begin
            r_rd_loaded <= 1'b1;
            if (!r_rd_loaded) begin
              r_rd_buf <= w_rd_val;
              r_miso   <= w_rd_val[DATA_W-1];
            end else begin
              r_rd_buf <= w_rd_shifted;
              r_miso   <= w_rd_shifted[DATA_W-1];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and commit outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is built from flops, not RAM, so it is reset
      // here to give downstream logic a defined value straight out of reset.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      wr_addr   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= r_commit_wr;
      frame_err <= r_commit_err;
      if (r_commit_wr) begin
        wr_addr <= r_commit_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_commit_addr == ADDR_W'(i)) r_regs[i] <= r_commit_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign miso    = r_miso;
  assign miso_oe = r_miso_oe;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_regfile_peripheral
//   Instance 4 uses the default parameters (mode 0). Instances 0..3 use
//   ADDR_W=3, DATA_W=16 and NUM_REGS=8, with {CPOL,CPHA} equal to the instance
//   index. A behavioural SPI master drives one instance at a time.
// -----------------------------------------------------------------------------
module tb_spi_regfile_peripheral;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sclk_r = 5'b0_1100;  // idle level = CPOL of each instance
  logic [4:0] cs_r   = 5'b1_1111;
  logic       mosi_r = 1'b0;

  wire  [4:0]   miso_a, oe_a, strobe_a, err_a;
  wire  [39:0]  d_regs;
  wire  [6:0]   d_wr_addr;
  wire  [127:0] sw_regs    [4];
  wire  [2:0]   sw_wr_addr [4];

  int tests = 0;
  int fails = 0;
  int strobe_cnt [5] = '{default: 0};
  int err_cnt    [5] = '{default: 0};

  always #5 clk = ~clk;

  spi_regfile_peripheral u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk_raw  (sclk_r[4]),
    .mosi_raw  (mosi_r),
    .cs_n_raw  (cs_r[4]),
    .miso      (miso_a[4]),
    .miso_oe   (oe_a[4]),
    .regs_flat (d_regs),
    .wr_strobe (strobe_a[4]),
    .wr_addr   (d_wr_addr),
    .frame_err (err_a[4])
  );

  for (genvar m = 0; m < 4; m++) begin : g_sweep
    spi_regfile_peripheral #(
      .ADDR_W(3), .DATA_W(16), .NUM_REGS(8), .CPOL(m / 2), .CPHA(m % 2)
    ) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk_raw  (sclk_r[m]),
      .mosi_raw  (mosi_r),
      .cs_n_raw  (cs_r[m]),
      .miso      (miso_a[m]),
      .miso_oe   (oe_a[m]),
      .regs_flat (sw_regs[m]),
      .wr_strobe (strobe_a[m]),
      .wr_addr   (sw_wr_addr[m]),
      .frame_err (err_a[m])
    );
  end

  // Pulse counters: a pulse longer than one cycle counts more than once.
  always @(posedge clk) begin
    for (int d = 0; d < 5; d++) begin
      if (strobe_a[d]) strobe_cnt[d] <= strobe_cnt[d] + 1;
      if (err_a[d])    err_cnt[d]    <= err_cnt[d] + 1;
    end
  end

  task automatic half_period();
    repeat (HALF) @(negedge clk);
  endtask

  // Drives nbits of tx (MSB first) with cs_n low; leaves cs_n low on return.
  // rx/oe collect miso/miso_oe as seen just before each sample edge.
  task automatic spi_frame(input int d, input logic [31:0] tx, input int nbits,
                           output logic [31:0] rx, output logic [31:0] oe);
    logic cpol, cpha;
    cpol = (d < 4) ? d[1] : 1'b0;
    cpha = (d < 4) ? d[0] : 1'b0;
    rx = '0;
    oe = '0;
    @(negedge clk);
    cs_r[d] = 1'b0;
    half_period();
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_r = tx[nbits-1-i];
        half_period();
        rx = {rx[30:0], miso_a[d]};
        oe = {oe[30:0], oe_a[d]};
        sclk_r[d] = ~cpol;
        half_period();
        sclk_r[d] = cpol;
      end else begin
        sclk_r[d] = ~cpol;
        mosi_r = tx[nbits-1-i];
        half_period();
        rx = {rx[30:0], miso_a[d]};
        oe = {oe[30:0], oe_a[d]};
        sclk_r[d] = cpol;
        half_period();
      end
    end
    half_period();
  endtask

  task automatic cs_release(input int d);
    @(negedge clk);
    cs_r[d] = 1'b1;
    mosi_r  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (d_regs !== 40'h0) begin fails++; $display("FAIL reset_regs: got %h, expected %h", d_regs, 40'h0); end
    tests++; if (d_wr_addr !== 7'h0) begin fails++; $display("FAIL reset_wr_addr: got %h, expected 0", d_wr_addr); end
    tests++; if ({strobe_a, err_a} !== 10'h0) begin fails++; $display("FAIL reset_pulses: got %b, expected 0", {strobe_a, err_a}); end
    tests++; if ({miso_a, oe_a} !== 10'h0) begin fails++; $display("FAIL reset_miso: got %b, expected 0", {miso_a, oe_a}); end
    for (int m = 0; m < 4; m++) begin
      tests++; if (sw_regs[m] !== 128'h0) begin fails++; $display("FAIL reset_sw_regs%0d: got %h, expected 0", m, sw_regs[m]); end
    end
  endtask

  task automatic test_write_mode0();
    logic [31:0] rx, oe;
    int s0, e0, first;
    logic [39:0] regs_at3;
    s0 = strobe_cnt[4]; e0 = err_cnt[4]; first = 0; regs_at3 = 'x;
    spi_frame(4, 32'h82A5, 16, rx, oe);
    tests++; if (oe[15:0] !== 16'h0) begin fails++; $display("FAIL write_oe: got %h, expected 0000", oe[15:0]); end
    @(negedge clk);
    cs_r[4] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) regs_at3 = d_regs;
      if (strobe_a[4] && first == 0) first = k;
    end
    repeat (8) @(negedge clk);
    tests++; if (first !== 4) begin fails++; $display("FAIL commit_latency: got %0d, expected 4", first); end
    tests++; if (regs_at3 !== 40'h0) begin fails++; $display("FAIL regs_before_commit: got %h, expected 0", regs_at3); end
    tests++; if (d_regs !== 40'h00_00A5_0000) begin fails++; $display("FAIL write_reg2: got %h, expected %h", d_regs, 40'h00_00A5_0000); end
    tests++; if (d_wr_addr !== 7'd2) begin fails++; $display("FAIL write_wr_addr: got %0d, expected 2", d_wr_addr); end
    tests++; if (strobe_cnt[4] - s0 !== 1) begin fails++; $display("FAIL write_strobe_cycles: got %0d, expected 1", strobe_cnt[4] - s0); end
    tests++; if (err_cnt[4] - e0 !== 0) begin fails++; $display("FAIL write_frame_err: got %0d, expected 0", err_cnt[4] - e0); end
  endtask

  task automatic test_read_back();
    logic [31:0] rx, oe;
    int s0, e0;
    s0 = strobe_cnt[4]; e0 = err_cnt[4];
    spi_frame(4, 32'h0200, 16, rx, oe);
    tests++; if (rx[7:0] !== 8'hA5) begin fails++; $display("FAIL read_data: got %h, expected a5", rx[7:0]); end
    tests++; if (oe[15:0] !== 16'h00FF) begin fails++; $display("FAIL read_oe_window: got %h, expected 00ff", oe[15:0]); end
    cs_release(4);
    tests++; if ({oe_a[4], miso_a[4]} !== 2'b00) begin fails++; $display("FAIL read_idle_pins: got %b, expected 00", {oe_a[4], miso_a[4]}); end
    tests++; if (d_regs !== 40'h00_00A5_0000) begin fails++; $display("FAIL read_regs_unchanged: got %h, expected %h", d_regs, 40'h00_00A5_0000); end
    tests++; if ((strobe_cnt[4] - s0) + (err_cnt[4] - e0) !== 0) begin fails++; $display("FAIL read_pulses: got %0d, expected 0", (strobe_cnt[4] - s0) + (err_cnt[4] - e0)); end
  endtask

  task automatic test_bad_length();
    logic [31:0] rx, oe;
    int s0, e0;
    s0 = strobe_cnt[4]; e0 = err_cnt[4];
    spi_frame(4, 32'h813C >> 6, 10, rx, oe);
    cs_release(4);
    tests++; if (err_cnt[4] - e0 !== 1) begin fails++; $display("FAIL short_frame_err: got %0d, expected 1", err_cnt[4] - e0); end
    spi_frame(4, 32'h813C << 2, 18, rx, oe);
    cs_release(4);
    tests++; if (err_cnt[4] - e0 !== 2) begin fails++; $display("FAIL long_frame_err: got %0d, expected 2", err_cnt[4] - e0); end
    tests++; if (strobe_cnt[4] - s0 !== 0) begin fails++; $display("FAIL bad_len_strobe: got %0d, expected 0", strobe_cnt[4] - s0); end
    tests++; if (d_regs !== 40'h00_00A5_0000) begin fails++; $display("FAIL bad_len_regs: got %h, expected %h", d_regs, 40'h00_00A5_0000); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rx, oe;
    int s0, e0;
    s0 = strobe_cnt[4]; e0 = err_cnt[4];
    spi_frame(4, 32'h875A, 16, rx, oe);
    cs_release(4);
    tests++; if (d_regs !== 40'h00_00A5_0000) begin fails++; $display("FAIL oor_write_regs: got %h, expected %h", d_regs, 40'h00_00A5_0000); end
    tests++; if (d_wr_addr !== 7'd2) begin fails++; $display("FAIL oor_wr_addr: got %0d, expected 2", d_wr_addr); end
    spi_frame(4, 32'h0700, 16, rx, oe);
    cs_release(4);
    tests++; if (rx[7:0] !== 8'h00) begin fails++; $display("FAIL oor_read_data: got %h, expected 00", rx[7:0]); end
    tests++; if ((strobe_cnt[4] - s0) + (err_cnt[4] - e0) !== 0) begin fails++; $display("FAIL oor_pulses: got %0d, expected 0", (strobe_cnt[4] - s0) + (err_cnt[4] - e0)); end
  endtask

  task automatic test_mode_sweep();
    logic [31:0] rx, oe;
    int s0, e0;
    for (int m = 0; m < 4; m++) begin
      s0 = strobe_cnt[m]; e0 = err_cnt[m];
      spi_frame(m, 32'hDBEEF, 20, rx, oe);
      cs_release(m);
      spi_frame(m, 32'h50000, 20, rx, oe);
      cs_release(m);
      tests++; if (sw_regs[m] !== 128'h0000_0000_BEEF_0000_0000_0000_0000_0000) begin fails++; $display("FAIL sweep%0d_regs: got %h, expected beef in reg5 only", m, sw_regs[m]); end
      tests++; if (rx[15:0] !== 16'hBEEF) begin fails++; $display("FAIL sweep%0d_read: got %h, expected beef", m, rx[15:0]); end
      tests++; if (sw_wr_addr[m] !== 3'd5) begin fails++; $display("FAIL sweep%0d_wr_addr: got %0d, expected 5", m, sw_wr_addr[m]); end
      tests++; if (strobe_cnt[m] - s0 !== 1 || err_cnt[m] - e0 !== 0) begin fails++; $display("FAIL sweep%0d_pulses: got strobe %0d err %0d, expected 1 and 0", m, strobe_cnt[m] - s0, err_cnt[m] - e0); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx, oe;
    int s0, e0;
    spi_frame(4, 32'h83FF >> 4, 12, rx, oe);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (d_regs !== 40'h0) begin fails++; $display("FAIL async_reset_regs: got %h, expected 0", d_regs); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    s0 = strobe_cnt[4]; e0 = err_cnt[4];
    spi_frame(4, 32'h8011, 16, rx, oe);
    cs_release(4);
    tests++; if (d_regs !== 40'h00_0000_0011) begin fails++; $display("FAIL post_reset_write: got %h, expected %h", d_regs, 40'h00_0000_0011); end
    tests++; if (d_wr_addr !== 7'd0) begin fails++; $display("FAIL post_reset_wr_addr: got %0d, expected 0", d_wr_addr); end
    tests++; if (strobe_cnt[4] - s0 !== 1 || err_cnt[4] - e0 !== 0) begin fails++; $display("FAIL post_reset_pulses: got strobe %0d err %0d, expected 1 and 0", strobe_cnt[4] - s0, err_cnt[4] - e0); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_write_mode0();
    test_read_back();
    test_bad_length();
    test_out_of_range();
    test_mode_sweep();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
